// File: rtl/mul_div_if.sv
// Execute-stage mul/div request/response bundle.
// The decode side issues operations; the unit returns busy/done and HI/LO.
interface mul_div_if;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_valid, md_op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  md_valid, md_op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply completes one cycle after issue; divide is a restoring divider
// producing one quotient bit per cycle, MSB first, on magnitudes, with the
// sign fixed up when the last bit is produced.
module mul_div_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst,
  mul_div_if.slave  md
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // Control state (reset)
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  // Operand / datapath state (no reset needed; only meaningful while busy)
  logic [31:0]      opa_q, opa_d;    // multiplicand, or dividend/quotient shift register
  logic [31:0]      opb_q, opb_d;    // multiplier, or divisor magnitude
  logic [31:0]      rem_q, rem_d;    // partial remainder
  logic [31:0]      orig_q, orig_d;  // raw dividend for the divide-by-zero result
  logic             msign_q, msign_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;

  logic             busy;
  logic             accept;
  logic             div_signed;
  logic [31:0]      a_abs;
  logic [31:0]      b_abs;

  logic signed [63:0] mul_a;
  logic signed [63:0] mul_b;
  logic signed [63:0] prod;

  logic [32:0]      rem_sh;
  logic [33:0]      diff;
  logic             q_bit;
  logic [31:0]      rem_nx;
  logic [31:0]      quo_nx;
  logic [31:0]      quo_fix;
  logic [31:0]      rem_fix;

  assign busy   = (state_q != IDLE);
  assign accept = md.md_valid & ~busy & ~md.flush;

  // Operand magnitudes for signed divide
  assign div_signed = (md.md_op == OP_DIV);
  assign a_abs = (div_signed && md.src_a[31]) ? (32'd0 - md.src_a) : md.src_a;
  assign b_abs = (div_signed && md.src_b[31]) ? (32'd0 - md.src_b) : md.src_b;

  // Sign-extending to 64 bits gives the exact product in the low 64 bits
  // for both the signed and unsigned flavours.
  assign mul_a = {{32{msign_q & opa_q[31]}}, opa_q};
  assign mul_b = {{32{msign_q & opb_q[31]}}, opb_q};
  assign prod  = mul_a * mul_b;

  // One restoring-division step: shift in next dividend bit, trial subtract
  assign rem_sh  = {rem_q, opa_q[31]};
  assign diff    = {1'b0, rem_sh} - {2'b00, opb_q};
  assign q_bit   = ~diff[33];
  assign rem_nx  = q_bit ? diff[31:0] : rem_sh[31:0];
  assign quo_nx  = {opa_q[30:0], q_bit};
  assign quo_fix = qneg_q ? (32'd0 - quo_nx) : quo_nx;
  assign rem_fix = rneg_q ? (32'd0 - rem_nx) : rem_nx;

  // Next-state, datapath and HI/LO update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    orig_d  = orig_q;
    msign_d = msign_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (md.md_op)
            OP_MULT, OP_MULTU: begin
              opa_d   = md.src_a;
              opb_d   = md.src_b;
              msign_d = (md.md_op == OP_MULT);
              state_d = MUL;
            end
            OP_DIV, OP_DIVU: begin
              opa_d   = a_abs;
              opb_d   = b_abs;
              rem_d   = 32'd0;
              orig_d  = md.src_a;
              qneg_d  = div_signed & (md.src_a[31] ^ md.src_b[31]);
              rneg_d  = div_signed & md.src_a[31];
              dbz_d   = (md.src_b == 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = DIV;
            end
            OP_MTHI: hi_d = md.src_a;
            OP_MTLO: lo_d = md.src_a;
            default: ;
          endcase
        end
      end
      MUL: begin
        state_d = IDLE;
        if (!md.flush) begin
          hi_d   = prod[63:32];
          lo_d   = prod[31:0];
          done_d = 1'b1;
        end
      end
      DIV: begin
        if (md.flush) begin
          state_d = IDLE;
        end else begin
          opa_d = quo_nx;
          rem_d = rem_nx;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (dbz_q) begin
              lo_d = 32'hFFFF_FFFF;
              hi_d = orig_q;
            end else begin
              lo_d = quo_fix;
              hi_d = rem_fix;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Operand and partial-result registers
  always_ff @(posedge clk) begin
    opa_q   <= opa_d;
    opb_q   <= opb_d;
    rem_q   <= rem_d;
    orig_q  <= orig_d;
    msign_q <= msign_d;
    qneg_q  <= qneg_d;
    rneg_q  <= rneg_d;
    dbz_q   <= dbz_d;
  end

  assign md.busy = busy;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: multiply/divide results, busy length,
// done pulse, flush, issue-while-busy, mthi/mtlo and asynchronous reset.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  mul_div_if bus ();

  mul_div_unit #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, then count busy cycles (bounded) until it drops.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
    bus.md_valid = 1'b1;
    bus.md_op    = op;
    bus.src_a    = a;
    bus.src_b    = b;
    step();
    bus.md_valid = 1'b0;
    bus.md_op    = 3'd0;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.md_valid = 1'b0;
    bus.md_op    = 3'd0;
    bus.src_a    = 32'd0;
    bus.src_b    = 32'd0;
    bus.flush    = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst = 1'b1;
    step();

    // mult -2 * 3
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("mult_cycles", cyc, 32'd1);
    chk("mult_done", {31'd0, bus.done}, 32'd1);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    step();
    chk("mult_done_clear", {31'd0, bus.done}, 32'd0);

    // multu same operands
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("multu_cycles", cyc, 32'd1);
    chk("multu_hi", bus.hi, 32'h0000_0002);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

    // div -7 / 2
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("div_cycles", cyc, 32'd32);
    chk("div_done", {31'd0, bus.done}, 32'd1);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    // divu same operands
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("divu_cycles", cyc, 32'd32);
    chk("divu_lo", bus.lo, 32'h7FFF_FFFC);
    chk("divu_hi", bus.hi, 32'd1);

    // signed overflow
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'd0);

    // signed divide by zero keeps the raw dividend in hi
    run_op(3'd3, 32'hFFFF_FFF9, 32'd0, cyc);
    chk("dbz_s_cycles", cyc, 32'd32);
    chk("dbz_s_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dbz_s_hi", bus.hi, 32'hFFFF_FFF9);

    // divu 100 / 0
    run_op(3'd4, 32'd100, 32'd0, cyc);
    chk("dbz_cycles", cyc, 32'd32);
    chk("dbz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dbz_hi", bus.hi, 32'd100);

    // div 1000/10 flushed at iteration cycle 10; mthi issued while busy is ignored
    bus.md_valid = 1'b1;
    bus.md_op    = 3'd3;
    bus.src_a    = 32'd1000;
    bus.src_b    = 32'd10;
    step();
    bus.md_valid = 1'b0;
    bus.md_op    = 3'd0;
    chk("fl_busy_start", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      if (i == 2) begin
        bus.md_valid = 1'b1;
        bus.md_op    = 3'd5;
        bus.src_a    = 32'hDEAD_BEEF;
      end else begin
        bus.md_valid = 1'b0;
        bus.md_op    = 3'd0;
      end
      step();
    end
    bus.md_valid = 1'b0;
    bus.md_op    = 3'd0;
    chk("fl_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_busy_after", {31'd0, bus.busy}, 32'd0);
    chk("fl_done_after", {31'd0, bus.done}, 32'd0);
    chk("fl_hi_kept", bus.hi, 32'd100);
    chk("fl_lo_kept", bus.lo, 32'hFFFF_FFFF);
    step();
    chk("fl_no_done", {31'd0, bus.done}, 32'd0);

    // flush and mthi together: flush wins
    bus.md_valid = 1'b1;
    bus.md_op    = 3'd5;
    bus.src_a    = 32'h5555_5555;
    bus.flush    = 1'b1;
    step();
    bus.md_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("flmt_hi", bus.hi, 32'd100);
    chk("flmt_busy", {31'd0, bus.busy}, 32'd0);

    // mthi then mtlo back-to-back
    bus.md_valid = 1'b1;
    bus.md_op    = 3'd5;
    bus.src_a    = 32'h1234_5678;
    step();
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    bus.md_op    = 3'd6;
    bus.src_a    = 32'h9ABC_DEF0;
    step();
    bus.md_valid = 1'b0;
    bus.md_op    = 3'd0;
    chk("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", bus.hi, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    chk("mtlo_done", {31'd0, bus.done}, 32'd0);

    // reserved op 7 ignored
    bus.md_valid = 1'b1;
    bus.md_op    = 3'd7;
    bus.src_a    = 32'h0BAD_0BAD;
    step();
    bus.md_valid = 1'b0;
    bus.md_op    = 3'd0;
    chk("op7_busy", {31'd0, bus.busy}, 32'd0);
    chk("op7_hi", bus.hi, 32'h1234_5678);
    chk("op7_lo", bus.lo, 32'h9ABC_DEF0);

    // divu interrupted by asynchronous reset mid-cycle
    bus.md_valid = 1'b1;
    bus.md_op    = 3'd4;
    bus.src_a    = 32'd1000;
    bus.src_b    = 32'd3;
    step();
    bus.md_valid = 1'b0;
    bus.md_op    = 3'd0;
    for (int i = 0; i < 14; i++) step();
    chk("ar_busy_before", {31'd0, bus.busy}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_busy", {31'd0, bus.busy}, 32'd0);
    chk("ar_hi", bus.hi, 32'd0);
    chk("ar_lo", bus.lo, 32'd0);
    step();
    rst = 1'b1;
    step();

    // mult 5 * 6 after reset release
    run_op(3'd1, 32'd5, 32'd6, cyc);
    chk("m56_cycles", cyc, 32'd1);
    chk("m56_lo", bus.lo, 32'd30);
    chk("m56_hi", bus.hi, 32'd0);
    chk("m56_done", {31'd0, bus.done}, 32'd1);

    // new mult accepted in the done cycle: 7 * -1
    run_op(3'd1, 32'd7, 32'hFFFF_FFFF, cyc);
    chk("bb_cycles", cyc, 32'd1);
    chk("bb_hi", bus.hi, 32'hFFFF_FFFF);
    chk("bb_lo", bus.lo, 32'hFFFF_FFF9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage, directly downstream of the decode/control unit. It consumes the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO operation plus rs/rt operand values.
- Drives HI/LO to the writeback mux for MFHI/MFLO.
- Raises busy so the pipeline stalls while an operation is in flight.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles for division (one quotient bit per cycle; fixed at 32 for 32-bit operands).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- md_valid  input  1  decoded mul/div/mthi/mtlo operation present this cycle.
- md_op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- src_a  input  32  rs value (dividend / multiplicand / mthi-mtlo data).
- src_b  input  32  rt value (divisor / multiplier).
- flush  input  1  cancels any in-flight operation (exception/redirect).
- busy  output  1  operation in progress; upstream must hold issue and stall MFHI/MFLO.
- done  output  1  one-cycle pulse after a mult/div result is written to HI/LO.
- hi  output  32  HI register value.
- lo  output  32  LO register value.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Applies mid-operation; the partial result is discarded.
- States: IDLE, MUL, DIV. busy = (state != IDLE).
- Accept condition: md_valid & ~busy & ~flush. md_valid while busy is ignored, with no queueing. md_op 0 or 7 is ignored.
- mthi/mtlo: on an accepting edge, hi (or lo) <= src_a. State stays IDLE, no busy, no done.
- mult/multu:
  - Accepting edge E0 latches operands; state=MUL.
  - Edge E1 writes the 64-bit product: hi=upper 32 bits, lo=lower 32 bits; state=IDLE.
  - busy=1 for exactly 1 cycle; done=1 in the cycle after E1.
  - mult treats operands as two's complement; multu treats them as unsigned.
- div/divu:
  - Accepting edge latches |src_a|, |src_b| (abs only for div), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]); counter=DIV_CYCLES-1; state=DIV.
  - Restoring algorithm, one quotient bit per edge, MSB first.
  - On the edge where counter==0: apply sign fixups, write lo=quotient and hi=remainder, state=IDLE.
  - busy=1 for exactly DIV_CYCLES cycles; done pulses the following cycle.
- Divide-by-zero (src_b==0): still takes DIV_CYCLES. Result is forced: lo=32'hFFFF_FFFF, hi=src_a (original, unsigned view). No exception raised.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF, div): lo=0x8000_0000, hi=0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- flush:
  - While busy: next edge returns to IDLE, hi/lo unchanged, no done.
  - flush with md_valid in the same cycle: flush wins and nothing is accepted. mthi/mtlo is also suppressed.
- done is never asserted in the same cycle as busy; a new operation may be accepted in the done cycle.
- hi/lo change only on result write, mthi/mtlo, or reset.

Test Plan:
- Reset then mult: src_a=0xFFFF_FFFE (-2), src_b=3 -> busy 1 cycle, done next cycle; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. Same operands via multu -> hi=0x0000_0002, lo=0xFFFF_FFFA.
- div: src_a=-7 (0xFFFF_FFF9), src_b=2 -> busy exactly 32 cycles; lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). Same operands via divu -> lo=0x7FFF_FFFC, hi=1.
- Boundary divides:
  - div 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
  - divu 100/0 -> after 32 cycles lo=0xFFFF_FFFF, hi=100.
- Start div 1000/10, assert flush at iteration cycle 10 -> busy drops next cycle, no done, hi/lo keep prior values. Also: md_valid during busy is ignored.
- mthi src_a=0x1234_5678, then mtlo src_a=0x9ABC_DEF0 on back-to-back cycles -> hi/lo updated one edge after each issue, busy never asserted.
- Start divu, pull rst low at cycle 15 (asynchronous, mid-cycle) -> hi=lo=0, busy=0 immediately. After release, mult 5*6 -> lo=30, hi=0.
